// File: rtl/ltc2387_decimator.sv
// Two-channel block-averaging decimator for the LTC2387 capture stream.
// Sums 2^log2_dec sample pairs and emits the floor average on a valid/ready port.
module ltc2387_decimator #(
  parameter int DATA_WIDTH   = 18,
  parameter int MAX_LOG2_DEC = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] adc0,
  input  logic [DATA_WIDTH-1:0] adc1,
  input  logic                  adc_valid,
  input  logic [3:0]            log2_dec,
  input  logic                  clear_ovf,
  output logic [DATA_WIDTH-1:0] m_data0,
  output logic [DATA_WIDTH-1:0] m_data1,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  overflow,
  output logic [31:0]           block_count
);

  localparam int ACC_W = DATA_WIDTH + MAX_LOG2_DEC;
  localparam int CNT_W = MAX_LOG2_DEC;

  function automatic logic [3:0] clamp_log2(input logic [3:0] v);
    if (int'(v) > MAX_LOG2_DEC) return 4'(MAX_LOG2_DEC);
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] block_avg(input logic signed [ACC_W-1:0] s,
                                                      input logic [3:0] sh);
    return DATA_WIDTH'(s >>> sh);
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              cur_log2_q, cur_log2_d;
  logic signed [ACC_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic [DATA_WIDTH-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic [31:0]             bcnt_q, bcnt_d;

  logic                    start, done, load, drop;
  logic [3:0]              eff_log2;
  logic [CNT_W:0]          block_len;
  logic signed [ACC_W-1:0] samp0, samp1, sum0, sum1;

  // A fresh block uses the live exponent; a block in progress keeps its latched one.
  assign start     = (cnt_q == '0);
  assign eff_log2  = start ? clamp_log2(log2_dec) : cur_log2_q;
  assign block_len = (CNT_W+1)'(1) << eff_log2;
  assign done      = adc_valid && ({1'b0, cnt_q} == (block_len - (CNT_W+1)'(1)));

  assign samp0 = {{MAX_LOG2_DEC{adc0[DATA_WIDTH-1]}}, adc0};
  assign samp1 = {{MAX_LOG2_DEC{adc1[DATA_WIDTH-1]}}, adc1};
  assign sum0  = (start ? '0 : acc0_q) + samp0;
  assign sum1  = (start ? '0 : acc1_q) + samp1;

  assign load = done && (!valid_q || m_ready);
  assign drop = done && valid_q && !m_ready;

  always_comb begin
    cnt_d      = cnt_q;
    cur_log2_d = cur_log2_q;
    acc0_d     = acc0_q;
    acc1_d     = acc1_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    bcnt_d     = bcnt_q;
    if (adc_valid) begin
      acc0_d = sum0;
      acc1_d = sum1;
      cnt_d  = done ? '0 : cnt_q + CNT_W'(1);
      if (start) cur_log2_d = eff_log2;
    end
    if (valid_q && m_ready) valid_d = 1'b0;
    if (load) begin
      data0_d = block_avg(sum0, eff_log2);
      data1_d = block_avg(sum1, eff_log2);
      valid_d = 1'b1;
      bcnt_d  = bcnt_q + 32'd1;
    end
    // A drop in the same cycle as a clear must leave the flag set.
    if (clear_ovf) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      cur_log2_q <= '0;
      acc0_q     <= '0;
      acc1_q     <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      bcnt_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      cur_log2_q <= cur_log2_d;
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      bcnt_q     <= bcnt_d;
    end
  end

  assign m_data0     = data0_q;
  assign m_data1     = data1_q;
  assign m_valid     = valid_q;
  assign overflow    = ovf_q;
  assign block_count = bcnt_q;

endmodule

// File: tb/tb_ltc2387_decimator.sv
// Directed bench for ltc2387_decimator with hand-computed expected averages.
module tb_ltc2387_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] adc0, adc1;
  logic        adc_valid;
  logic [3:0]  log2_dec;
  logic        clear_ovf;
  logic [17:0] m_data0, m_data1;
  logic        m_valid;
  logic        m_ready;
  logic        overflow;
  logic [31:0] block_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ltc2387_decimator #(.DATA_WIDTH(18), .MAX_LOG2_DEC(10)) dut (
    .clk(clk), .rst(rst), .adc0(adc0), .adc1(adc1), .adc_valid(adc_valid),
    .log2_dec(log2_dec), .clear_ovf(clear_ovf), .m_data0(m_data0), .m_data1(m_data1),
    .m_valid(m_valid), .m_ready(m_ready), .overflow(overflow), .block_count(block_count)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a0, input int a1);
    adc0      = 18'(a0);
    adc1      = 18'(a1);
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; adc0 = '0; adc1 = '0; adc_valid = 1'b0;
    log2_dec = 4'd0; clear_ovf = 1'b0; m_ready = 1'b0;
    step(); step();
    chk("rst_valid", m_valid, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_bcnt",  block_count, 0);
    chk("rst_d0",    $signed(m_data0), 0);
    chk("rst_d1",    $signed(m_data1), 0);
    rst = 1'b0;
    step();

    // Four-sample average on both channels
    log2_dec = 4'd2; m_ready = 1'b1;
    send(4, -4); send(8, -8); send(12, -12);
    chk("avg4_not_yet", m_valid, 0);
    send(16, -16);
    chk("avg4_valid", m_valid, 1);
    chk("avg4_d0", $signed(m_data0), 10);
    chk("avg4_d1", $signed(m_data1), -10);
    chk("avg4_bcnt", block_count, 1);
    step();
    chk("avg4_consumed", m_valid, 0);

    // Floor rounding and range extremes
    log2_dec = 4'd1;
    send(-1, 0); send(-2, 0);
    chk("floor_d0", $signed(m_data0), -2);
    send(131071, 0); send(131071, 0);
    chk("maxpos_d0", $signed(m_data0), 131071);
    log2_dec = 4'd10;
    for (int i = 0; i < 1024; i++) send(-131072, 7);
    chk("maxneg_d0", $signed(m_data0), -131072);
    chk("maxneg_d1", $signed(m_data1), 7);
    chk("maxneg_bcnt", block_count, 4);

    // Pass-through at full rate
    log2_dec = 4'd0;
    for (int i = 0; i < 8; i++) begin
      adc0 = 18'(i); adc1 = 18'(-i); adc_valid = 1'b1;
      step();
      chk("ramp_valid", m_valid, 1);
      chk("ramp_d0", $signed(m_data0), i);
      chk("ramp_d1", $signed(m_data1), -i);
    end
    adc_valid = 1'b0;
    chk("ramp_bcnt", block_count, 12);
    chk("ramp_ovf", overflow, 0);
    step();
    chk("ramp_drain", m_valid, 0);

    // Backpressure: hold, drop, sticky flag
    log2_dec = 4'd1; m_ready = 1'b0;
    send(2, 0); send(4, 0);
    chk("bp_first_valid", m_valid, 1);
    chk("bp_first_d0", $signed(m_data0), 3);
    send(10, 0); send(20, 0);
    chk("bp_held_d0", $signed(m_data0), 3);
    chk("bp_ovf", overflow, 1);
    chk("bp_bcnt", block_count, 13);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    chk("bp_drained", m_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    chk("bp_cleared", overflow, 0);
    send(2, 0); send(2, 0);
    chk("bp_reload_d0", $signed(m_data0), 2);
    chk("bp_reload_bcnt", block_count, 14);
    send(6, 0);
    clear_ovf = 1'b1;
    send(8, 0);
    clear_ovf = 1'b0;
    chk("bp_set_wins", overflow, 1);
    chk("bp_set_wins_d0", $signed(m_data0), 2);
    chk("bp_set_wins_bcnt", block_count, 14);
    m_ready = 1'b1; step();
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    chk("bp_final_clear", overflow, 0);

    // Exponent change mid-block takes effect at the next block
    log2_dec = 4'd2;
    send(1, 0); send(3, 0);
    log2_dec = 4'd0;
    send(5, 0);
    chk("switch_no_early", m_valid, 0);
    send(7, 0);
    chk("switch_d0", $signed(m_data0), 4);
    chk("switch_bcnt", block_count, 15);
    send(9, 0);
    chk("switch_pass_a", $signed(m_data0), 9);
    send(-5, 0);
    chk("switch_pass_b", $signed(m_data0), -5);
    chk("switch_bcnt2", block_count, 17);

    // Asynchronous reset mid-block discards the partial sum
    m_ready = 1'b0; log2_dec = 4'd2;
    send(1, 0); send(1, 0); send(1, 0);
    chk("prerst_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_bcnt", block_count, 0);
    chk("arst_d0", $signed(m_data0), 0);
    chk("arst_ovf", overflow, 0);
    step();
    rst = 1'b0;
    step();
    m_ready = 1'b1;
    send(1, 0); send(1, 0); send(1, 0);
    chk("postrst_wait", m_valid, 0);
    send(5, 0);
    chk("postrst_d0", $signed(m_data0), 2);
    chk("postrst_bcnt", block_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
